matrix_frame_scheduler: RTL
===========================

# matrix_frame_scheduler

Sequences glyph frames into the 8x8 APA102 matrix serializer. Holds a small message buffer of glyph/colour entries and hands one frame descriptor at a time to the serializer over a valid/ready handshake. Repeats each entry a configurable number of frames, then advances through the message with wrap-around. Inserts a fixed idle gap between frames. Sits between the top-level io pins / config logic and the bit-banged strip serializer.

## Interface
- `MSG_DEPTH`, 8: message buffer entries; power of two; address width `AW = log2(MSG_DEPTH)`.
- `GAP_CYCLES`, 1000: idle cycles between frames; must be ≥ 1.
- `clk  in  1`: clock. One clock domain only.
- `reset  in  1`: reset, synchronous, active-high.
- `wr_en  in  1`: message buffer write strobe.
- `wr_addr  in  AW`: write address.
- `wr_data  in  8`: entry. [7] blank, [6:5] palette select, [1:0] glyph index. [4:2] are ignored and stored as 0.
- `cfg_len  in  AW`: message length minus 1.
- `cfg_repeat  in  4`: frames per entry; 0 is treated as 1.
- `run  in  1`: enable sequencing.
- `frm_valid  out  1`: frame descriptor valid.
- `frm_ready  in  1`: serializer accepts the descriptor.
- `frm_done  in  1`: one-cycle pulse from the serializer after the end frame is emitted.
- `frm_glyph  out  2`: font index.
- `frm_on  out  32`: LED word for lit pixels.
- `frm_off  out  32`: LED word for unlit pixels.
- `busy  out  1`: high in every state except IDLE.
- `pos  out  AW`: current message index.
- `frame_cnt  out  8`: count of completed frames; wraps at 255→0.

## Operation
- **Palette.**
  - 0 = 32'hF00F0000
  - 1 = 32'hF0000F00
  - 2 = 32'hF000000F
  - 3 = 32'hF00F0F0F
  - Off word is always 32'hF0000000.
  - For a blank entry, `frm_on` = `frm_off` = 32'hF0000000.
- **Buffer reset contents.**
  - Entries 0..4 = glyphs 0,1,2,2,3 with palette 0 (spells "hello").
  - All other entries are blank.
- **States.** IDLE, ISSUE, WAIT_DONE, GAP.
- **IDLE.**
  - When `run`=1: load the descriptor from entry 0, set `pos`=0 and the repeat count `rep`=0, latch `len`=`cfg_len`, set `frm_valid`<=1, go to ISSUE.
- **ISSUE.**
  - `frm_valid`=1. The descriptor is held stable until accepted.
  - When `frm_ready`=1: `frm_valid`<=0, go to WAIT_DONE.
  - `run` is ignored in this state.
- **WAIT_DONE.** When `frm_done`=1:
  - Increment `frame_cnt`.
  - If `rep`+1 ≥ effective repeat: set `rep`=0, then advance `pos`. If `pos`==`len`, wrap `pos` to 0 and re-latch `len`=`cfg_len`; otherwise increment `pos`.
  - Otherwise: increment `rep`.
  - Next state is GAP if `run`=1, else IDLE.
- **GAP.**
  - Count `GAP_CYCLES` cycles.
  - On the final cycle: load the descriptor from entry `pos`, set `frm_valid`<=1, go to ISSUE.
  - If `run`=0 on any GAP cycle, go to IDLE instead; the frame is not issued.
- **Buffer writes.**
  - Writes are accepted in every state except during `reset`.
  - A descriptor is registered when it is loaded. A later write to the same entry does not alter an outstanding frame.
  - A write and a load of the same address in the same cycle: the load sees the old data.
- **Ignored inputs.**
  - `frm_done` is ignored outside WAIT_DONE.
  - `frm_ready` is ignored outside ISSUE.
- **`cfg_len` changes** take effect only at IDLE→ISSUE or at a wrap. If `pos` is greater than the newly latched `len`, this cannot occur, because `pos` is 0 at both latch points.

## Timing
- **Reset values.**
  - `frm_valid`=0, `frm_glyph`=0, `frm_on`=0, `frm_off`=0, `busy`=0, `pos`=0, `frame_cnt`=0.
  - State = IDLE, `rep`=0, gap counter = 0, `len`=0.
  - The buffer is restored to its reset contents.
- **Reset mid-operation** aborts immediately to reset values on the next edge. `frm_valid` drops even if the frame is unaccepted.
- **Start latency.** `run` sampled high in IDLE at edge N → `frm_valid` high after edge N+1.
- **Handshake.** A transfer occurs on an edge where `frm_valid`&&`frm_ready`. `frm_valid` deasserts on that same edge.
- **Done-to-next latency.** `frm_done` sampled at edge D (with `run`=1) → `frm_valid` high after edge D+GAP_CYCLES+1.
- **Output updates.**
  - `pos` and `frame_cnt` update on the `frm_done` edge.
  - `frm_*` outputs update only on load edges.
- **All outputs are registered.** There are no combinational paths from inputs to outputs.

## Test plan
- **Reset then start.** Reset, `cfg_len`=4, `cfg_repeat`=1, `GAP_CYCLES`=4, `run`=1, `frm_ready`=1, `frm_done` pulsed 10 cycles after each accept. Expect:
  - Glyph sequence 0,1,2,2,3,0.
  - `frm_on`=32'hF00F0000 and `frm_off`=32'hF0000000 throughout.
  - `frm_valid` rises exactly 5 cycles after each `frm_done`.
- **Repeat.** `cfg_repeat`=3. Expect each glyph issued 3 times before `pos` increments. After 15 frames `pos` wraps to 0 and `frame_cnt`=15.
- **Backpressure.** Hold `frm_ready`=0 for 20 cycles in ISSUE. Expect `frm_valid` and the descriptor stable for all 20 cycles, with a single transfer when ready rises.
- **Write / blank / palette.**
  - Write entry 1 = 8'hC1 (blank) while `pos`=1 in WAIT_DONE. Expect the current frame unchanged; the next pass issues `frm_on`=`frm_off`=32'hF0000000.
  - Write entry 2 = 8'h42. Expect `frm_on`=32'hF000000F with glyph 2.
- **Run drop.**
  - Deassert `run` during GAP. Expect IDLE next edge, no `frm_valid`, `busy`=0.
  - Deassert `run` in WAIT_DONE. Expect the frame to complete, `frame_cnt` to increment, then IDLE.
- **Reset mid-frame.** Assert `reset` during ISSUE with an unaccepted descriptor. Expect all outputs at reset values next cycle, and the buffer back to "hello".

Source files
------------

// File: rtl/matrix_frame_scheduler.sv
// Frame sequencer for the 8x8 APA102 matrix: walks a small glyph/colour message
// buffer and hands one registered frame descriptor at a time to the serializer.
module matrix_frame_scheduler #(
   parameter int MSG_DEPTH  = 8,
   parameter int GAP_CYCLES = 1000,
   localparam int AW = $clog2(MSG_DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   input  logic [AW-1:0] cfg_len,
   input  logic [3:0]    cfg_repeat,
   input  logic          run,
   output logic          frm_valid,
   input  logic          frm_ready,
   input  logic          frm_done,
   output logic [1:0]    frm_glyph,
   output logic [31:0]   frm_on,
   output logic [31:0]   frm_off,
   output logic          busy,
   output logic [AW-1:0] pos,
   output logic [7:0]    frame_cnt
);

   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [31:0] OFF_WORD = 32'hF0000000;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, GAP} state_t;

   state_t        r_state;
   state_t        w_nextState;
   logic [7:0]    r_mem [MSG_DEPTH];
   logic [AW-1:0] r_pos;
   logic [AW-1:0] r_len;
   logic [3:0]    r_rep;
   logic [GW-1:0] r_gapCnt;
   logic          r_frmValid;
   logic [1:0]    r_glyph;
   logic [31:0]   r_on;
   logic [31:0]   r_off;
   logic          r_busy;
   logic [7:0]    r_frameCnt;
   logic          w_load;
   logic [AW-1:0] w_loadAddr;
   logic [4:0]    w_effRep;
   logic          w_lastRep;

   function automatic logic [31:0] paletteWord(input logic [1:0] sel);
      case (sel)
         2'd0:    paletteWord = 32'hF00F0000;
         2'd1:    paletteWord = 32'hF0000F00;
         2'd2:    paletteWord = 32'hF000000F;
         default: paletteWord = 32'hF00F0F0F;
      endcase
   endfunction

   // Power-up message spells "hello" with glyphs 0,1,2,2,3; the rest is blank.
   function automatic logic [7:0] resetEntry(input int idx);
      case (idx)
         0:       resetEntry = 8'h00;
         1:       resetEntry = 8'h01;
         2:       resetEntry = 8'h02;
         3:       resetEntry = 8'h02;
         4:       resetEntry = 8'h03;
         default: resetEntry = 8'h80;
      endcase
   endfunction

   assign w_effRep  = (cfg_repeat == 4'd0) ? 5'd1 : {1'b0, cfg_repeat};
   assign w_lastRep = (({1'b0, r_rep} + 5'd1) >= w_effRep);

   always_comb begin
      w_nextState = r_state;
      w_load      = 1'b0;
      w_loadAddr  = r_pos;
      case (r_state)
         IDLE: begin
            if (run) begin
               w_nextState = ISSUE;
               w_load      = 1'b1;
               w_loadAddr  = '0;
            end
         end
         ISSUE: begin
            if (frm_ready) w_nextState = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (frm_done) w_nextState = run ? GAP : IDLE;
         end
         GAP: begin
            if (!run) begin
               w_nextState = IDLE;
            end else if (r_gapCnt == GW'(GAP_CYCLES - 1)) begin
               w_nextState = ISSUE;
               w_load      = 1'b1;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // The descriptor is captured from the buffer on the load edge, so later writes
   // to the same entry never disturb a frame that is already outstanding.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_pos      <= '0;
         r_len      <= '0;
         r_rep      <= '0;
         r_gapCnt   <= '0;
         r_frmValid <= 1'b0;
         r_glyph    <= '0;
         r_on       <= '0;
         r_off      <= '0;
         r_busy     <= 1'b0;
         r_frameCnt <= '0;
         for (int i = 0; i < MSG_DEPTH; i++) r_mem[i] <= resetEntry(i);
      end else begin
         r_state <= w_nextState;
         r_busy  <= (w_nextState != IDLE);
         if (wr_en) r_mem[wr_addr] <= wr_data & 8'hE3;
         if (w_load) begin
            r_frmValid <= 1'b1;
            r_glyph    <= r_mem[w_loadAddr][1:0];
            r_on       <= r_mem[w_loadAddr][7] ? OFF_WORD : paletteWord(r_mem[w_loadAddr][6:5]);
            r_off      <= OFF_WORD;
         end else if (r_state == ISSUE && frm_ready) begin
            r_frmValid <= 1'b0;
         end
         if (r_state == IDLE && run) begin
            r_pos <= '0;
            r_rep <= '0;
            r_len <= cfg_len;
         end
         if (r_state == WAIT_DONE && frm_done) begin
            r_frameCnt <= r_frameCnt + 8'd1;
            r_gapCnt   <= '0;
            if (w_lastRep) begin
               r_rep <= '0;
               if (r_pos == r_len) begin
                  r_pos <= '0;
                  r_len <= cfg_len;
               end else begin
                  r_pos <= r_pos + AW'(1);
               end
            end else begin
               r_rep <= r_rep + 4'd1;
            end
         end
         if (r_state == GAP) r_gapCnt <= r_gapCnt + GW'(1);
      end
   end

   assign frm_valid = r_frmValid;
   assign frm_glyph = r_glyph;
   assign frm_on    = r_on;
   assign frm_off   = r_off;
   assign busy      = r_busy;
   assign pos       = r_pos;
   assign frame_cnt = r_frameCnt;

endmodule
